// File: rtl/act_pkg.sv
// Shared defaults and the tag-width helper for the activation arbiter slice.
package act_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int FRACTION_DEF        = 16;
  localparam int NUM_REQ_DEF         = 4;
  localparam int MAX_OUTSTANDING_DEF = 8;

  // A tag must be at least one bit wide even for two requesters.
  function automatic int tag_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/act_tag_fifo.sv
// In-order FIFO of requester tags for results still inside the sigmoid pipeline.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module act_tag_fifo #(
  parameter int pWIDTH = 2,
  parameter int pDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [pWIDTH-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [pWIDTH-1:0]        pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(pDEPTH):0]  count_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(pDEPTH);

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == DEPTH_CNT);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin front end sharing one sigmoid pipeline among pNUM_REQ requesters.
// Define ACT_ARB_ERR_EN to enable the sticky orphan-result flag on o_err.
module act_arbiter
  import act_pkg::*;
#(
  parameter int pDATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int pFRACTION        = FRACTION_DEF,
  parameter int pNUM_REQ         = NUM_REQ_DEF,
  parameter int pMAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [pNUM_REQ-1:0]             req_valid,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] req_data,
  output logic [pNUM_REQ-1:0]             req_ready,
  output logic                            act_valid,
  output logic [pDATA_WIDTH-1:0]          act_data,
  input  logic                            act_o_valid,
  input  logic [pDATA_WIDTH-1:0]          act_o_data,
  output logic [pNUM_REQ-1:0]             rsp_valid,
  output logic [pDATA_WIDTH-1:0]          rsp_data,
  output logic                            o_err
);

  localparam int TW = tag_width(pNUM_REQ);
  localparam int CW = $clog2(pMAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(pMAX_OUTSTANDING);

  // The fraction point only matters to the sigmoid; reject nonsense early.
  if (pFRACTION >= pDATA_WIDTH || pNUM_REQ < 2 || pNUM_REQ > 8) begin : g_param_chk
    $error("act_arbiter: bad parameter combination");
  end

  logic [TW-1:0]          rr_q, rr_d;
  logic [TW-1:0]          cand, grant_idx, pop_tag;
  logic [pNUM_REQ-1:0]    grant;
  logic [pDATA_WIDTH-1:0] grant_data;
  logic                   credit, xfer, pop;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_cnt;
  logic                   act_valid_q;
  logic [pDATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [pNUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [pDATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Scan offsets from farthest to nearest so the nearest valid requester after rr_q wins.
  always_comb begin
    cand      = rr_q;
    grant_idx = rr_q;
    for (int off = pNUM_REQ; off >= 1; off--) begin
      cand = TW'((int'(rr_q) + off) % pNUM_REQ);
      if (req_valid[cand]) grant_idx = cand;
    end
    grant = '0;
    if (|req_valid) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (grant_idx == TW'(i)) grant_data = req_data[i*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

  assign credit    = (fifo_cnt < MAX_CNT) || (fifo_full && act_o_valid);
  assign req_ready = (rst_n && credit) ? grant : '0;
  assign xfer      = |req_ready;
  assign rr_d      = xfer ? grant_idx : rr_q;
  assign pop       = act_o_valid && !fifo_empty;
  assign act_data_d = xfer ? grant_data : act_data_q;
  assign rsp_data_d = pop ? act_o_data : rsp_data_q;

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      rsp_valid_d[i] = pop && (pop_tag == TW'(i));
    end
  end

  act_tag_fifo #(
    .pWIDTH (TW),
    .pDEPTH (pMAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (xfer),
    .push_data_i (grant_idx),
    .pop_i       (act_o_valid),
    .pop_data_o  (pop_tag),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= TW'(pNUM_REQ - 1);
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      act_valid_q <= xfer;
      act_data_q  <= act_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign act_valid = act_valid_q;
  assign act_data  = act_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef ACT_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (act_o_valid && fifo_empty) begin
      err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_act_arbiter.sv
// Directed bench for act_arbiter with a behavioural 4-cycle sigmoid stand-in.
module tb_act_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int L  = 4;
`ifdef ACT_ARB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_ov = 1'b0;

  logic [NR-1:0]    req_valid, req_ready, rsp_valid;
  logic [NR*DW-1:0] req_data;
  logic             act_valid, act_o_valid, o_err;
  logic [DW-1:0]    act_data, act_o_data, rsp_data;

  logic [NR-1:0]    req_valid2, req_ready2, rsp_valid2;
  logic [NR*DW-1:0] req_data2;
  logic             act_valid2, act_o_valid2, o_err2;
  logic [DW-1:0]    act_data2, act_o_data2, rsp_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .act_valid(act_valid), .act_data(act_data),
    .act_o_valid(act_o_valid), .act_o_data(act_o_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .o_err(o_err)
  );

  act_arbiter #(.pMAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .act_valid(act_valid2), .act_data(act_data2),
    .act_o_valid(act_o_valid2), .act_o_data(act_o_data2), .rsp_valid(rsp_valid2),
    .rsp_data(rsp_data2), .o_err(o_err2)
  );

  function automatic logic [DW-1:0] sig(input logic [DW-1:0] x);
    if (x == 32'h0001_0000) return 32'h0000_BB0F;
    return x ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [DW-1:0] lane(input int v, input int i);
    return 32'hA000_0000 + DW'(v * 16 + i);
  endfunction

  function automatic int idx_of(input logic [NR-1:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Sigmoid stand-ins, reset by the same rst_n as the arbiters.
  logic [L-1:0]  sv_q, sv2_q;
  logic [DW-1:0] sd_q [L];
  logic [DW-1:0] sd2_q [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q  <= '0;
      sv2_q <= '0;
      for (int i = 0; i < L; i++) begin
        sd_q[i]  <= '0;
        sd2_q[i] <= '0;
      end
    end else begin
      sv_q     <= {sv_q[L-2:0], act_valid};
      sv2_q    <= {sv2_q[L-2:0], act_valid2};
      sd_q[0]  <= sig(act_data);
      sd2_q[0] <= sig(act_data2);
      for (int i = 1; i < L; i++) begin
        sd_q[i]  <= sd_q[i-1];
        sd2_q[i] <= sd2_q[i-1];
      end
    end
  end
  assign act_o_valid  = sv_q[L-1] | force_ov;
  assign act_o_data   = sd_q[L-1];
  assign act_o_valid2 = sv2_q[L-1];
  assign act_o_data2  = sd2_q[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("orphan_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_onehot", 64'(rsp_valid), 64'(1) << e.idx);
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] r;
  } vec_t;
  vec_t tbl[16];
  logic cr[12];

  initial begin
    int n;
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0100};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0010};
    tbl[5]  = '{4'b1111, 4'b0100};
    tbl[6]  = '{4'b1111, 4'b1000};
    tbl[7]  = '{4'b1111, 4'b0001};
    tbl[8]  = '{4'b1010, 4'b0010};
    tbl[9]  = '{4'b1010, 4'b1000};
    tbl[10] = '{4'b0010, 4'b0010};
    tbl[11] = '{4'b0010, 4'b0010};
    tbl[12] = '{4'b0001, 4'b0001};
    tbl[13] = '{4'b0000, 4'b0000};
    tbl[14] = '{4'b0101, 4'b0100};
    tbl[15] = '{4'b0101, 4'b0001};
    cr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state with requests pending
    req_valid  = 4'b1111;
    req_data   = {4{32'hFFFF_FFFF}};
    req_valid2 = '0;
    req_data2  = {4{32'h1234_5678}};
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_act_valid", 64'(act_valid), 64'd0);
    chk("rst_act_data", 64'(act_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_o_err", 64'(o_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;

    // Round-robin table
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      req_valid = tbl[k].v;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane(k, i);
      @(negedge clk);
      chk("rr_ready", 64'(req_ready), 64'(tbl[k].r));
      if (k > 0) begin
        chk("act_valid", 64'(act_valid), 64'(|tbl[k-1].r));
        if (|tbl[k-1].r) chk("act_data", 64'(act_data), 64'(lane(k-1, idx_of(tbl[k-1].r))));
      end
      if (|tbl[k].r) sb.push_back('{idx_of(tbl[k].r), sig(lane(k, idx_of(tbl[k].r)))});
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("act_valid_last", 64'(act_valid), 64'd1);
    chk("act_data_last", 64'(act_data), 64'(lane(15, 0)));
    drain();

    // Single request latency: 1 + L + 1
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data[0 +: DW] = 32'h0001_0000;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0001);
    sb.push_back('{0, 32'h0000_BB0F});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_act_valid", 64'(act_valid), 64'd1);
    chk("single_act_data", 64'(act_data), 64'h0001_0000);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 20);
    chk("rsp_latency", 64'(n), 64'(2 + L));
    drain();

    // Credit limit of 2 with latency 4
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req_valid2 = 4'b0001;
      @(negedge clk);
      chk("credit_ready", 64'(req_ready2[0]), 64'(cr[c]));
    end
    @(posedge clk); #1;
    req_valid2 = '0;

    // Orphan result
    @(posedge clk); #1;
    force_ov = 1'b1;
    @(posedge clk); #1;
    force_ov = 1'b0;
    @(negedge clk);
    chk("orphan_no_rsp", 64'(rsp_valid), 64'd0);
    chk("orphan_err", 64'(o_err), 64'(EXP_ERR));
    repeat (3) @(negedge clk);
    chk("orphan_err_sticky", 64'(o_err), 64'(EXP_ERR));
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 32'h0BAD_0001;
    @(negedge clk);
    chk("post_orphan_ready", 64'(req_ready), 64'b0010);
    sb.push_back('{1, sig(32'h0BAD_0001)});
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset with three results outstanding
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 4'b0111;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane(40 + c, i);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_act_valid", 64'(act_valid), 64'd0);
    chk("midrst_act_data", 64'(act_data), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
    chk("midrst_o_err", 64'(o_err), 64'd0);
    sb.delete();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hC0DE_0002;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", 64'(req_ready), 64'b0100);
    sb.push_back('{2, sig(32'hC0DE_0002)});
    @(posedge clk); #1;
    req_valid = 4'b1111;
    req_data[3*DW +: DW] = 32'hC0DE_0003;
    @(negedge clk);
    chk("postrst_rr", 64'(req_ready), 64'b1000);
    chk("postrst_act_data", 64'(act_data), 64'hC0DE_0002);
    sb.push_back('{3, sig(32'hC0DE_0003)});
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
